// File: rtl/mc_fifo_pkg.sv
// Shared defaults and width helpers for the multi-channel FIFO.
package mc_fifo_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 32;
    localparam int DEF_CHANNELS  = 4;
    localparam int DEF_AF_MARGIN = 2;
    localparam int DEF_AE_MARGIN = 2;

    // Bits needed to index n items; a single item still needs a one-bit select.
    function automatic int width_of(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mc_fifo_ctrl.sv
// Per-channel pointer, occupancy and status logic for one logical FIFO.
// Optional sticky error flags are built when MC_FIFO_ERR_EN is defined.
module mc_fifo_ctrl
    import mc_fifo_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_MARGIN = DEF_AF_MARGIN,
    parameter int AE_MARGIN = DEF_AE_MARGIN
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_req,
    input  logic                       rd_req,
    input  logic                       clear_err,
    output logic                       wr_acc,
    output logic                       rd_acc,
    output logic [width_of(DEPTH)-1:0] wr_ptr,
    output logic [width_of(DEPTH)-1:0] rd_ptr,
    output logic [width_of(DEPTH):0]   count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW    = width_of(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Status comes straight from the registered count, so it lags the causing edge by one cycle.
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(DEPTH - AF_MARGIN));
    assign almost_empty = (count_q <= CNT_W'(AE_MARGIN));

    // Accept decisions use only pre-edge state: no bypass from write to read.
    assign wr_acc = wr_req && !full;
    assign rd_acc = rd_req && !empty;

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

    // Next pointers wrap naturally because DEPTH is a power of two; count tracks net change.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef MC_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Clear drops old flags; a new rejection in the same cycle still sets its flag.
    always_comb begin
        overflow_d  = clear_err ? 1'b0 : overflow_q;
        underflow_d = clear_err ? 1'b0 : underflow_q;
        if (wr_req && full) begin
            overflow_d = 1'b1;
        end
        if (rd_req && empty) begin
            underflow_d = 1'b1;
        end
    end

    // Sticky error flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_clear_err;
    assign unused_clear_err = clear_err;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

endmodule

// File: rtl/mc_fifo.sv
// Multi-channel FIFO: CHANNELS logical FIFOs sharing one storage array
// addressed {channel, pointer}, with a registered read port.
// Optional sticky overflow/underflow flags: define MC_FIFO_ERR_EN.
module mc_fifo
    import mc_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int AF_MARGIN = DEF_AF_MARGIN,
    parameter int AE_MARGIN = DEF_AE_MARGIN
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          write_en,
    input  logic [width_of(CHANNELS)-1:0] wr_ch,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          read_en,
    input  logic [width_of(CHANNELS)-1:0] rd_ch,
    input  logic                          clear_err,
    output logic [WIDTH-1:0]              data_out,
    output logic                          data_valid,
    output logic [CHANNELS-1:0]           full,
    output logic [CHANNELS-1:0]           empty,
    output logic [CHANNELS-1:0]           almost_full,
    output logic [CHANNELS-1:0]           almost_empty,
    output logic [width_of(DEPTH):0]      rd_count,
    output logic [CHANNELS-1:0]           overflow,
    output logic [CHANNELS-1:0]           underflow
);

    localparam int CW    = width_of(CHANNELS);
    localparam int AW    = width_of(DEPTH);
    localparam int MEM_N = CHANNELS * DEPTH;

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("mc_fifo: DEPTH must be a power of two and at least 4");
    end
    if (CHANNELS < 1) begin : g_bad_channels
        $error("mc_fifo: CHANNELS must be at least 1");
    end
    if ((AF_MARGIN < 1) || (AF_MARGIN > DEPTH - 1)) begin : g_bad_af
        $error("mc_fifo: AF_MARGIN must be in 1..DEPTH-1");
    end
    if ((AE_MARGIN < 1) || (AE_MARGIN > DEPTH - 1)) begin : g_bad_ae
        $error("mc_fifo: AE_MARGIN must be in 1..DEPTH-1");
    end

    logic [CHANNELS-1:0] wr_req, rd_req, wr_acc, rd_acc;
    logic [AW-1:0]       wr_ptr_a [CHANNELS];
    logic [AW-1:0]       rd_ptr_a [CHANNELS];
    logic [AW:0]         count_a  [CHANNELS];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        // Out-of-range channel selects match no instance and are therefore ignored.
        assign wr_req[g] = write_en && (wr_ch == CW'(g));
        assign rd_req[g] = read_en && (rd_ch == CW'(g));

        mc_fifo_ctrl #(
            .DEPTH     (DEPTH),
            .AF_MARGIN (AF_MARGIN),
            .AE_MARGIN (AE_MARGIN)
        ) u_ctrl (
            .clk          (clk),
            .reset        (reset),
            .wr_req       (wr_req[g]),
            .rd_req       (rd_req[g]),
            .clear_err    (clear_err),
            .wr_acc       (wr_acc[g]),
            .rd_acc       (rd_acc[g]),
            .wr_ptr       (wr_ptr_a[g]),
            .rd_ptr       (rd_ptr_a[g]),
            .count        (count_a[g]),
            .full         (full[g]),
            .empty        (empty[g]),
            .almost_full  (almost_full[g]),
            .almost_empty (almost_empty[g]),
            .overflow     (overflow[g]),
            .underflow    (underflow[g])
        );
    end

    logic [AW-1:0]      wr_ptr_sel, rd_ptr_sel;
    logic [AW:0]        rd_count_sel;
    logic [CW+AW-1:0]   wr_addr, rd_addr;
    logic [WIDTH-1:0]   mem_q [MEM_N];
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               data_valid_q, data_valid_d;

    // Pick the selected channel's pointers and occupancy; unmatched selects yield zero.
    always_comb begin
        wr_ptr_sel   = '0;
        rd_ptr_sel   = '0;
        rd_count_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_ch == CW'(i)) begin
                wr_ptr_sel = wr_ptr_a[i];
            end
            if (rd_ch == CW'(i)) begin
                rd_ptr_sel   = rd_ptr_a[i];
                rd_count_sel = count_a[i];
            end
        end
    end

    assign wr_addr  = {wr_ch, wr_ptr_sel};
    assign rd_addr  = {rd_ch, rd_ptr_sel};
    assign rd_count = rd_count_sel;

    // Shared storage; deliberately not reset, occupancy alone defines valid contents.
    always_ff @(posedge clk) begin
        if (|wr_acc) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    // Output word updates only on an accepted read; otherwise it holds.
    always_comb begin
        data_valid_d = |rd_acc;
        data_out_d   = data_out_q;
        if (|rd_acc) begin
            data_out_d = mem_q[rd_addr];
        end
    end

    // Registered read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_mc_fifo.sv
// Self-checking bench for mc_fifo at default parameters.
// Handshake: write/read requests are single-cycle pulses sampled at the
// rising edge; data_valid marks a new data_out for exactly one cycle.
module tb_mc_fifo;

  logic       clk;
  logic       reset;
  logic       write_en;
  logic [1:0] wr_ch;
  logic [7:0] data_in;
  logic       read_en;
  logic [1:0] rd_ch;
  logic       clear_err;
  logic [7:0] data_out;
  logic       data_valid;
  logic [3:0] full, empty, almost_full, almost_empty;
  logic [5:0] rd_count;
  logic [3:0] overflow, underflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_q [4][$];
  logic [7:0] exp_q[$];
  logic [3:0] ov_m = '0;
  logic [3:0] uf_m = '0;

  mc_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .write_en     (write_en),
    .wr_ch        (wr_ch),
    .data_in      (data_in),
    .read_en      (read_en),
    .rd_ch        (rd_ch),
    .clear_err    (clear_err),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .rd_count     (rd_count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, elapsed=%0t limit=500000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every data_valid pops one expected word
  always @(negedge clk) begin
    if (!reset && data_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("dv_spurious", {31'd0, data_valid}, 32'd0);
      end else begin
        check_eq("rd_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // driver: one clock of requests; model updated with pre-edge decisions
  task automatic do_cycle(input logic we, input logic [1:0] wch, input logic [7:0] din,
                          input logic re, input logic [1:0] rch, input logic clr);
    bit wacc, racc;
    logic [7:0] tmp;
    write_en  = we;
    wr_ch     = wch;
    data_in   = din;
    read_en   = re;
    rd_ch     = rch;
    clear_err = clr;
    wacc = we && (model_q[wch].size() < 32);
    racc = re && (model_q[rch].size() > 0);
    if (racc) exp_q.push_back(model_q[rch][0]);
    @(posedge clk);
    #1;
`ifdef MC_FIFO_ERR_EN
    if (clr) begin
      ov_m = '0;
      uf_m = '0;
    end
    if (we && !wacc) ov_m[wch] = 1'b1;
    if (re && !racc) uf_m[rch] = 1'b1;
`endif
    if (racc) tmp = model_q[rch].pop_front();
    if (wacc) model_q[wch].push_back(din);
    write_en  = 1'b0;
    read_en   = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic status_cmp(input string tag);
    logic [3:0] f, e, af, ae;
    for (int i = 0; i < 4; i++) begin
      f[i]  = (model_q[i].size() == 32);
      e[i]  = (model_q[i].size() == 0);
      af[i] = (model_q[i].size() >= 30);
      ae[i] = (model_q[i].size() <= 2);
    end
    check_eq({tag, "_full"},  {28'd0, full},         {28'd0, f});
    check_eq({tag, "_empty"}, {28'd0, empty},        {28'd0, e});
    check_eq({tag, "_af"},    {28'd0, almost_full},  {28'd0, af});
    check_eq({tag, "_ae"},    {28'd0, almost_empty}, {28'd0, ae});
    check_eq({tag, "_ovf"},   {28'd0, overflow},     {28'd0, ov_m});
    check_eq({tag, "_unf"},   {28'd0, underflow},    {28'd0, uf_m});
    for (int i = 0; i < 4; i++) begin
      rd_ch = 2'(i);
      #1;
      check_eq({tag, "_rdcnt"}, {26'd0, rd_count}, model_q[i].size());
    end
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    status_cmp(tag);
  endtask

  task automatic drain(input logic [1:0] ch);
    while (model_q[ch].size() > 0) do_cycle(1'b0, 2'd0, 8'd0, 1'b1, ch, 1'b0);
  endtask

  initial begin
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    reset = 1'b0; write_en = 1'b0; wr_ch = '0; data_in = '0;
    read_en = 1'b0; rd_ch = '0; clear_err = 1'b0;

    // reset state
    #2 reset = 1'b1;
    #1;
    status_cmp("rst");
    check_eq("rst_dv",   {31'd0, data_valid}, 32'd0);
    check_eq("rst_dout", {24'd0, data_out},   32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // four words through channel 1
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 2'd1, vals[i], 1'b0, 2'd0, 1'b0);
    check_status("ch1_wr");
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 2'd0, 8'd0, 1'b1, 2'd1, 1'b0);
    check_status("ch1_rd");
    do_cycle(1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b0);
    check_eq("hold_dout", {24'd0, data_out}, 32'h44);
    check_eq("hold_dv",   {31'd0, data_valid}, 32'd0);

    // fill channel 0 to full, overflow, read back
    for (int i = 1; i <= 32; i++) begin
      do_cycle(1'b1, 2'd0, 8'($urandom_range(0, 255)), 1'b0, 2'd0, 1'b0);
      if (i >= 28) check_status("fill");
    end
    do_cycle(1'b1, 2'd0, 8'hEE, 1'b0, 2'd0, 1'b0);
    check_status("ovf");
    drain(2'd0);
    check_status("fill_drain");

    // interleave channel 2/3 writes with a 40-word stream through channel 0
    for (int i = 0; i < 80; i++) begin
      if (i % 2 == 0)
        do_cycle(1'b1, 2'd0, 8'($urandom_range(0, 255)), model_q[0].size() > 2, 2'd0, 1'b0);
      else
        do_cycle(1'b1, (i % 4 == 1) ? 2'd2 : 2'd3, 8'($urandom_range(0, 255)),
                 model_q[0].size() > 0, 2'd0, 1'b0);
    end
    check_status("stream");
    drain(2'd0);
    drain(2'd2);
    drain(2'd3);
    check_status("stream_drain");

    // simultaneous write+read on a full channel and at mid occupancy
    for (int i = 0; i < 32; i++) do_cycle(1'b1, 2'd0, 8'($urandom_range(0, 255)), 1'b0, 2'd0, 1'b0);
    check_status("full2");
    do_cycle(1'b1, 2'd0, 8'hAA, 1'b1, 2'd0, 1'b0);
    check_status("full_wr_rd");
    while (model_q[0].size() > 16) do_cycle(1'b0, 2'd0, 8'd0, 1'b1, 2'd0, 1'b0);
    do_cycle(1'b1, 2'd0, 8'h5A, 1'b1, 2'd0, 1'b0);
    check_status("mid_wr_rd");
    drain(2'd0);
    check_status("mid_drain");

    // underflow on empty channel 2 and clear behaviour
    do_cycle(1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b1);
    check_status("clr0");
    do_cycle(1'b0, 2'd0, 8'd0, 1'b1, 2'd2, 1'b0);
    check_eq("unf_dv", {31'd0, data_valid}, 32'd0);
    check_status("unf");
    do_cycle(1'b0, 2'd0, 8'd0, 1'b1, 2'd2, 1'b1);
    check_status("clr_new_err");
    do_cycle(1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b1);
    check_status("clr1");

    // reset in the middle of operation with a read result pending
    for (int i = 0; i < 10; i++) do_cycle(1'b1, 2'd1, 8'($urandom_range(0, 255)), 1'b0, 2'd0, 1'b0);
    do_cycle(1'b0, 2'd0, 8'd0, 1'b1, 2'd1, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) model_q[i].delete();
    ov_m = '0;
    uf_m = '0;
    #1;
    check_eq("mid_rst_dv",   {31'd0, data_valid}, 32'd0);
    check_eq("mid_rst_dout", {24'd0, data_out},   32'd0);
    status_cmp("mid_rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_cycle(1'b0, 2'd0, 8'd0, 1'b1, 2'd1, 1'b0);
    check_eq("post_rst_dv", {31'd0, data_valid}, 32'd0);
    check_status("post_rst");

    @(negedge clk);
    check_eq("exp_q_left", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_fifo.md
MC_FIFO -- requirements
Module: mc_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits.
REQ-002 Parameter DEPTH, default 32: entries per channel; power of two, >=4.
REQ-003 Parameter CHANNELS, default 4: number of independent logical FIFOs, >=1.
REQ-004 Parameter AF_MARGIN, default 2: almost_full when count >= DEPTH-AF_MARGIN; range 1..DEPTH-1.
REQ-005 Parameter AE_MARGIN, default 2: almost_empty when count <= AE_MARGIN; range 1..DEPTH-1.
REQ-006 Illegal parameter values SHALL cause an elaboration error. CW = max(1, clog2(CHANNELS)); AW = clog2(DEPTH).
REQ-007 clk  in  1  single clock; all state changes on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 write_en  in  1  write request.
REQ-010 wr_ch  in  CW  write channel select.
REQ-011 data_in  in  WIDTH  write data.
REQ-012 read_en  in  1  read request.
REQ-013 rd_ch  in  CW  read channel select.
REQ-014 clear_err  in  1  clears sticky error flags.
REQ-015 data_out  out  WIDTH  registered read data.
REQ-016 data_valid  out  1  data_out holds newly read word this cycle.
REQ-017 full, empty, almost_full, almost_empty  out  CHANNELS each  per-channel status, bit i = channel i.
REQ-018 rd_count  out  AW+1  occupancy of channel rd_ch.
REQ-019 overflow, underflow  out  CHANNELS each  sticky per-channel error flags.

Function
REQ-020 Per channel: wr_ptr, rd_ptr (AW bits, wrap DEPTH-1 -> 0) and count (AW+1 bits); storage addressed {channel, pointer}.
REQ-021 Write accepted iff write_en && !full[wr_ch] && wr_ch < CHANNELS; stores data_in, wr_ptr+1.
REQ-022 Read accepted iff read_en && !empty[rd_ch] && rd_ch < CHANNELS; next edge data_out <= head word, data_valid = 1 for one cycle, rd_ptr+1.
REQ-023 Without an accepted read, data_valid = 0 and data_out holds its last value.
REQ-024 Accept decisions use pre-edge state: full channel with simultaneous write+read -> read accepted, write rejected; empty channel -> read rejected, no write-to-read bypass.
REQ-025 Simultaneous accepted write and read on the same channel: count unchanged; on different channels: each count moves independently.
REQ-026 full = (count==DEPTH), empty = (count==0), almost flags per REQ-004/005; all decoded from registered counts, visible the cycle after the causing edge.
REQ-027 rd_count is a combinational select of count[rd_ch]; 0 when rd_ch >= CHANNELS.
REQ-028 Rejected or out-of-range requests SHALL change no pointer, count or storage.

Reset
REQ-029 reset asserted SHALL immediately clear all pointers, counts, data_out (0), data_valid (0), overflow/underflow (0); empty and almost_empty all 1, full and almost_full all 0; storage not reset.
REQ-030 Reset mid-operation discards all contents and any pending data_valid; first accepted access after release sees empty FIFOs.

Configuration
REQ-031 With MC_FIFO_ERR_EN defined: rejected write on full channel sets overflow[wr_ch]; rejected read on empty channel sets underflow[rd_ch]; clear_err clears all flags, a same-cycle new error wins for its bit.
REQ-032 Without MC_FIFO_ERR_EN: overflow and underflow tied to 0, clear_err ignored; ports remain.

Structure
REQ-033 Package mc_fifo_pkg SHALL hold default parameter constants and the width helper function for CW/AW.
REQ-034 Per-channel pointer/count/flag logic SHALL be sub-module mc_fifo_ctrl, generated CHANNELS times; storage and output register in mc_fifo.

Verification (WIDTH=8, DEPTH=32, CHANNELS=4, margins 2)
REQ-035 Write 0x11,0x22,0x33,0x44 to ch1, read ch1 x4 -> data_out 0x11..0x44 one cycle after each read, data_valid pulses, empty[1]=1 at end, ch0/2/3 untouched.
REQ-036 32 writes to ch0 -> almost_full[0] after write 30, full[0] after 32; write 33 rejected, overflow[0]=1 (macro on); readback returns all 32 in order.
REQ-037 Interleave writes ch2/ch3, stream 40 words through ch0 -> per-channel order kept, pointer wrap lossless.
REQ-038 ch0 full, write+read same cycle -> count 31, write dropped; at count 16 write+read -> count 16.
REQ-039 Read empty ch2 -> data_valid 0, underflow[2]=1, cleared by clear_err; macro off -> stays 0.
REQ-040 Assert reset mid-edge with 10 entries in ch1 -> empty all 1, data_valid 0 immediately; after release read ch1 rejected.
